// File: rtl/mem_pkg.sv
// Shared constants and encodings for the system RAM arbiter.
package mem_pkg;

  localparam int MEM_AW = 20;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_VID = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Two-way grant picker: fixed video priority or round-robin against the last grant.
module arb_pick2
  import mem_pkg::*;
#(
  parameter int VID_PRIORITY = 0
) (
  input  logic cpu_elig,
  input  logic vid_elig,
  input  logic last_grant,
  output logic valid,
  output logic owner
);

  always_comb begin
    valid = cpu_elig | vid_elig;
    owner = OWN_CPU;
    if (cpu_elig && vid_elig) begin
      if (VID_PRIORITY != 0) begin
        owner = OWN_VID;
      end else begin
        // Round-robin: the port that did not win last time goes now.
        owner = (last_grant == OWN_CPU) ? OWN_VID : OWN_CPU;
      end
    end else if (vid_elig) begin
      owner = OWN_VID;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port system RAM between the CPU and the read-only video fetch port.
//   state | meaning
//   IDLE  | no access in flight; arbitrate and register the winner's address
//   ADDR  | RAM samples address (and write data when writing)
//   WAIT  | count down remaining RAM read latency
//   DONE  | owner's ack high for one cycle; arbitrate again for back-to-back
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW           = MEM_AW,
  parameter int DW           = MEM_DW,
  parameter int MEM_LATENCY  = 1,
  parameter int VID_PRIORITY = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_o_data,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_i_data,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_address,
  output logic [DW-1:0] vid_i_data,
  output logic          vid_ack,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_o_data,
  output logic          mem_we,
  input  logic [DW-1:0] mem_i_data
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

  state_t     state;
  logic       owner_q;
  logic       wr_q;
  logic       last_grant;
  logic [2:0] lat_cnt;

  logic cpu_elig;
  logic vid_elig;
  logic pick_valid;
  logic pick_owner;

  // A port in its ack cycle is still holding req; it must not be re-granted.
  assign cpu_elig = cpu_req & ~cpu_ack;
  assign vid_elig = vid_req & ~vid_ack;

  arb_pick2 #(
    .VID_PRIORITY(VID_PRIORITY)
  ) u_pick (
    .cpu_elig  (cpu_elig),
    .vid_elig  (vid_elig),
    .last_grant(last_grant),
    .valid     (pick_valid),
    .owner     (pick_owner)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner_q     <= OWN_CPU;
      wr_q        <= 1'b0;
      last_grant  <= OWN_VID;
      lat_cnt     <= '0;
      mem_address <= '0;
      mem_o_data  <= '0;
      mem_we      <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_i_data  <= '0;
      vid_i_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          cpu_ack <= 1'b0;
          vid_ack <= 1'b0;
          mem_we  <= 1'b0;
          if (pick_valid) begin
            state      <= ADDR;
            owner_q    <= pick_owner;
            last_grant <= pick_owner;
            lat_cnt    <= LAT_INIT;
            if (pick_owner == OWN_CPU) begin
              mem_address <= cpu_address;
              mem_o_data  <= cpu_o_data;
              mem_we      <= cpu_we;
              wr_q        <= cpu_we;
            end else begin
              mem_address <= vid_address;
              wr_q        <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end

        ADDR: begin
          mem_we <= 1'b0;
          state  <= WAIT;
        end

        WAIT: begin
          if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else begin
            state <= DONE;
            if (owner_q == OWN_CPU) begin
              cpu_ack <= 1'b1;
              if (!wr_q) cpu_i_data <= mem_i_data;
            end else begin
              vid_ack    <= 1'b1;
              vid_i_data <= mem_i_data;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: round-robin instance with a RAM model, plus a video-priority instance on a ROM.
module tb_mem_arbiter;
  import mem_pkg::*;

  typedef struct packed {
    logic       port;
    logic       rd;
    logic [7:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        cpu_req = 1'b0;
  logic [19:0] cpu_address = '0;
  logic [7:0]  cpu_o_data = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_i_data;
  logic        cpu_ack;
  logic        vid_req = 1'b0;
  logic [19:0] vid_address = '0;
  logic [7:0]  vid_i_data;
  logic        vid_ack;
  logic [19:0] mem_address;
  logic [7:0]  mem_o_data;
  logic        mem_we;
  logic [7:0]  mem_i_data;

  logic        p_cpu_req = 1'b0;
  logic [19:0] p_cpu_address = '0;
  logic [7:0]  p_cpu_i_data;
  logic        p_cpu_ack;
  logic        p_vid_req = 1'b0;
  logic [19:0] p_vid_address = '0;
  logic [7:0]  p_vid_i_data;
  logic        p_vid_ack;
  logic [19:0] p_mem_address;
  logic [7:0]  p_mem_o_data;
  logic        p_mem_we;
  logic [7:0]  p_mem_i_data;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  logic [7:0] shadow [logic [19:0]];
  logic [7:0] cpu_rd_last = '0;

  always #5 clock = ~clock;

  mem_arbiter #(.MEM_LATENCY(1), .VID_PRIORITY(0)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_o_data(cpu_o_data),
    .cpu_we(cpu_we), .cpu_i_data(cpu_i_data), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_address(vid_address), .vid_i_data(vid_i_data),
    .vid_ack(vid_ack), .mem_address(mem_address), .mem_o_data(mem_o_data),
    .mem_we(mem_we), .mem_i_data(mem_i_data)
  );

  mem_arbiter #(.MEM_LATENCY(1), .VID_PRIORITY(1)) dut_p (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(p_cpu_req), .cpu_address(p_cpu_address), .cpu_o_data(8'h00),
    .cpu_we(1'b0), .cpu_i_data(p_cpu_i_data), .cpu_ack(p_cpu_ack),
    .vid_req(p_vid_req), .vid_address(p_vid_address), .vid_i_data(p_vid_i_data),
    .vid_ack(p_vid_ack), .mem_address(p_mem_address), .mem_o_data(p_mem_o_data),
    .mem_we(p_mem_we), .mem_i_data(p_mem_i_data)
  );

  // Synchronous RAM: writes and registers read data on the edge it samples the address.
  logic [7:0]  ram [0:1048575];
  logic [7:0]  rd_q = '0;
  logic        pre_we = 1'b0;
  logic [19:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  always @(posedge clock) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_address] <= mem_o_data;
    rd_q <= ram[mem_address];
  end
  assign mem_i_data = rd_q;

  logic [7:0] p_rd_q = '0;
  always @(posedge clock) p_rd_q <= p_mem_address[7:0] ^ 8'h5A;
  assign p_mem_i_data = p_rd_q;

  task automatic preload(input logic [19:0] addr, input logic [7:0] data);
    pre_addr = addr;
    pre_data = data;
    pre_we = 1'b1;
    shadow[addr] = data;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cpu_rd_last = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total++; if (mem_address !== 20'h0 || mem_o_data !== 8'h0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL reset_mem: addr=%h data=%h we=%b want 0", mem_address, mem_o_data, mem_we);
    end
    total++; if (cpu_ack !== 1'b0 || vid_ack !== 1'b0) begin
      bad++; $display("FAIL reset_ack: cpu_ack=%b vid_ack=%b want 0", cpu_ack, vid_ack);
    end
    total++; if (cpu_i_data !== 8'h0 || vid_i_data !== 8'h0) begin
      bad++; $display("FAIL reset_idata: cpu=%h vid=%h want 0", cpu_i_data, vid_i_data);
    end
    total++; if (dut.state !== IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want IDLE", dut.state);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One CPU access from idle: checks address timing, latency, write pulse, data, ack width.
  task automatic do_cpu(input logic [19:0] addr, input logic we, input logic [7:0] wdata);
    int n;
    int we_cycles;
    exp_t e;
    exp_t got;
    e.port = OWN_CPU;
    e.rd = ~we;
    e.data = we ? 8'h00 : shadow[addr];
    if (we) shadow[addr] = wdata;
    exp_q.push_back(e);
    cpu_address = addr;
    cpu_we = we;
    cpu_o_data = wdata;
    cpu_req = 1'b1;
    n = 0;
    we_cycles = 0;
    do begin
      @(negedge clock);
      n++;
      if (mem_we) we_cycles++;
      if (n == 1) begin
        total++; if (mem_address !== addr) begin
          bad++; $display("FAIL cpu_mem_addr: got %h want %h", mem_address, addr);
        end
      end
      if (vid_ack !== 1'b0) begin
        total++; bad++; $display("FAIL cpu_vid_ack: vid_ack=1 want 0 at cycle %0d", n);
      end
    end while (!cpu_ack && n < 20);
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    total++; if (n !== 3) begin
      bad++; $display("FAIL cpu_latency: ack after %0d cycles want 3", n);
    end
    total++; if (we_cycles !== (we ? 1 : 0)) begin
      bad++; $display("FAIL cpu_we_pulse: mem_we high %0d cycles want %0d", we_cycles, we ? 1 : 0);
    end
    if (exp_q.size() == 0) begin
      total++; bad++; $display("FAIL cpu_scoreboard: ack with empty queue");
    end else begin
      got = exp_q.pop_front();
      total++;
      if (got.rd) begin
        if (cpu_i_data !== got.data) begin
          bad++; $display("FAIL cpu_rdata: got %h want %h", cpu_i_data, got.data);
        end
        cpu_rd_last = got.data;
      end else if (cpu_i_data !== cpu_rd_last) begin
        bad++; $display("FAIL cpu_wr_idata: got %h want held %h", cpu_i_data, cpu_rd_last);
      end
    end
    @(negedge clock);
    total++; if (cpu_ack !== 1'b0) begin
      bad++; $display("FAIL cpu_ack_width: ack still high, want 1-cycle pulse");
    end
  endtask

  task automatic test_cpu_read();
    preload(20'h12345, 8'hA5);
    do_cpu(20'h12345, 1'b0, 8'h00);
  endtask

  task automatic test_write_read();
    do_cpu(20'hFFFFF, 1'b1, 8'h3C);
    total++; if (ram[20'hFFFFF] !== 8'h3C) begin
      bad++; $display("FAIL wr_ram: ram[FFFFF]=%h want 3c", ram[20'hFFFFF]);
    end
    do_cpu(20'hFFFFF, 1'b0, 8'h00);
  endtask

  task automatic test_contention_rr();
    exp_t e;
    exp_t got;
    int n;
    int last_n;
    int acks;
    apply_reset();
    preload(20'h00010, 8'h11);
    preload(20'h00020, 8'h22);
    // After reset the CPU wins the first contest, then grants alternate.
    for (int i = 0; i < 4; i++) begin
      e.port = (i % 2 == 0) ? OWN_CPU : OWN_VID;
      e.rd = 1'b1;
      e.data = (i % 2 == 0) ? 8'h11 : 8'h22;
      exp_q.push_back(e);
    end
    cpu_address = 20'h00010;
    vid_address = 20'h00020;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    vid_req = 1'b1;
    n = 0; last_n = 0; acks = 0;
    while (acks < 4 && n < 60) begin
      @(negedge clock);
      n++;
      if (cpu_ack && vid_ack) begin
        total++; bad++; $display("FAIL rr_both_ack: both acks high at cycle %0d", n);
      end else if (cpu_ack || vid_ack) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL rr_scoreboard: extra ack at cycle %0d", n);
        end else begin
          got = exp_q.pop_front();
          total++; if ((vid_ack ? OWN_VID : OWN_CPU) !== got.port) begin
            bad++; $display("FAIL rr_order: ack %0d port=%b want %b", acks, vid_ack, got.port);
          end
          total++; if ((vid_ack ? vid_i_data : cpu_i_data) !== got.data) begin
            bad++; $display("FAIL rr_data: ack %0d got %h want %h", acks,
                            vid_ack ? vid_i_data : cpu_i_data, got.data);
          end
        end
        if (acks > 0) begin
          total++; if (n - last_n !== 3) begin
            bad++; $display("FAIL rr_spacing: %0d cycles between acks want 3", n - last_n);
          end
        end
        last_n = n;
        acks++;
        if (acks == 4) begin
          cpu_req = 1'b0;
          vid_req = 1'b0;
        end
      end
    end
    total++; if (acks !== 4) begin
      bad++; $display("FAIL rr_timeout: %0d acks want 4", acks);
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
  endtask

  // A lone requester that keeps req high is re-granted after one idle cycle: 4-cycle spacing.
  task automatic test_vid_stream();
    exp_t e;
    exp_t got;
    int n;
    int last_n;
    int acks;
    for (int i = 0; i < 4; i++) begin
      preload(20'(i), 8'hC0 + 8'(i * 7));
      e.port = OWN_VID;
      e.rd = 1'b1;
      e.data = 8'hC0 + 8'(i * 7);
      exp_q.push_back(e);
    end
    vid_address = 20'h00000;
    vid_req = 1'b1;
    n = 0; last_n = 0; acks = 0;
    while (acks < 4 && n < 60) begin
      @(negedge clock);
      n++;
      if (cpu_ack) begin
        total++; bad++; $display("FAIL vs_cpu_ack: cpu_ack=1 want 0 at cycle %0d", n);
      end
      if (vid_ack) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL vs_scoreboard: extra ack");
        end else begin
          got = exp_q.pop_front();
          total++; if (vid_i_data !== got.data) begin
            bad++; $display("FAIL vs_data: ack %0d got %h want %h", acks, vid_i_data, got.data);
          end
        end
        if (acks > 0) begin
          total++; if (n - last_n !== 4) begin
            bad++; $display("FAIL vs_spacing: %0d cycles want 4", n - last_n);
          end
        end
        last_n = n;
        acks++;
        vid_address = 20'(acks);
        if (acks == 4) vid_req = 1'b0;
      end
    end
    total++; if (acks !== 4) begin
      bad++; $display("FAIL vs_timeout: %0d acks want 4", acks);
    end
    vid_req = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
  endtask

  task automatic test_priority();
    exp_t e;
    exp_t got;
    int n;
    int acks;
    int ack_n [2];
    apply_reset();
    e.port = OWN_VID; e.rd = 1'b1; e.data = 8'h44 ^ 8'h5A;
    exp_q.push_back(e);
    e.port = OWN_CPU; e.rd = 1'b1; e.data = 8'h33 ^ 8'h5A;
    exp_q.push_back(e);
    p_cpu_address = 20'h00033;
    p_vid_address = 20'h00044;
    p_cpu_req = 1'b1;
    p_vid_req = 1'b1;
    n = 0; acks = 0;
    while (acks < 2 && n < 40) begin
      @(negedge clock);
      n++;
      if (p_cpu_ack || p_vid_ack) begin
        if (exp_q.size() == 0 || (p_cpu_ack && p_vid_ack)) begin
          total++; bad++; $display("FAIL pri_ack: unexpected ack cpu=%b vid=%b", p_cpu_ack, p_vid_ack);
        end else begin
          got = exp_q.pop_front();
          total++; if ((p_vid_ack ? OWN_VID : OWN_CPU) !== got.port) begin
            bad++; $display("FAIL pri_order: ack %0d port=%b want %b", acks, p_vid_ack, got.port);
          end
          total++; if ((p_vid_ack ? p_vid_i_data : p_cpu_i_data) !== got.data) begin
            bad++; $display("FAIL pri_data: ack %0d got %h want %h", acks,
                            p_vid_ack ? p_vid_i_data : p_cpu_i_data, got.data);
          end
        end
        ack_n[acks] = n;
        acks++;
        if (p_vid_ack) p_vid_req = 1'b0;
        if (p_cpu_ack) p_cpu_req = 1'b0;
      end
    end
    total++; if (acks !== 2 || ack_n[0] !== 3 || ack_n[1] !== 6) begin
      bad++; $display("FAIL pri_timing: %0d acks at %0d/%0d want 2 at 3/6", acks, ack_n[0], ack_n[1]);
    end
    p_cpu_req = 1'b0;
    p_vid_req = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid_write();
    int stray;
    preload(20'h00400, 8'h99);
    cpu_address = 20'h00400;
    cpu_o_data = 8'h55;
    cpu_we = 1'b1;
    cpu_req = 1'b1;
    @(negedge clock);
    total++; if (mem_we !== 1'b1 || dut.state !== ADDR) begin
      bad++; $display("FAIL mid_pre: mem_we=%b state=%0d want 1/ADDR", mem_we, dut.state);
    end
    #2 reset_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0 || cpu_ack !== 1'b0 || vid_ack !== 1'b0 || dut.state !== IDLE) begin
      bad++; $display("FAIL mid_reset: we=%b cpu_ack=%b vid_ack=%b state=%0d want 0/0/0/IDLE",
                      mem_we, cpu_ack, vid_ack, dut.state);
    end
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cpu_rd_last = '0;
    stray = 0;
    repeat (6) begin
      @(negedge clock);
      if (cpu_ack || vid_ack) stray++;
    end
    total++; if (stray !== 0) begin
      bad++; $display("FAIL mid_stray_ack: %0d acks want 0", stray);
    end
    total++; if (ram[20'h00400] !== 8'h99) begin
      bad++; $display("FAIL mid_ram: ram[400]=%h want 99", ram[20'h00400]);
    end
    do_cpu(20'h00400, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_read();
    test_contention_rr();
    test_vid_stream();
    test_priority();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
